// File: rtl/bus_mem_ctrl_pkg.sv
// Shared types for the cache-bus responder: request packet, FSM state, block geometry.
// Block size and beat width live here so the packet layout and the controller agree.
package bus_mem_ctrl_pkg;

    localparam int BLOCK_SIZE     = 4;
    localparam int DMA_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      we;
        logic [31:0]               addr;
        logic [BLOCK_SIZE*32-1:0]  wdata;
    } cache_bus_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } bus_mem_state_e;

endpackage

// File: rtl/bus_mem_ctrl_if.sv
// Cache request/response and memory beat signals between one cache, the controller and main memory.
// Signal names are from the controller's side; slave = controller, master = cache plus memory.
interface bus_mem_ctrl_if
    import bus_mem_ctrl_pkg::*;
#(
    parameter int dma_data_width_p = DMA_DATA_WIDTH
) ();

    logic                        cb_valid_i;
    logic                        cb_yumi_o;
    cache_bus_pkt_t              cb_pkt_i;
    logic                        cb_valid_o;
    logic [dma_data_width_p-1:0] cb_data_o;

    logic                        mem_valid_o;
    logic                        mem_ready_i;
    logic                        mem_we_o;
    logic [31:0]                 mem_addr_o;
    logic [dma_data_width_p-1:0] mem_wdata_o;
    logic                        mem_valid_i;
    logic [dma_data_width_p-1:0] mem_data_i;

    modport slave (
        input  cb_valid_i, cb_pkt_i, mem_ready_i, mem_valid_i, mem_data_i,
        output cb_yumi_o, cb_valid_o, cb_data_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cb_valid_i, cb_pkt_i, mem_ready_i, mem_valid_i, mem_data_i,
        input  cb_yumi_o, cb_valid_o, cb_data_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/bus_mem_ctrl.sv
// Single-cache block transfer engine: splits one cache packet into memory beats, streams read beats back.
// Latency: per beat >=1 REQ cycle + memory latency + 1 registered response cycle.
// Backpressure: mem_ready_i stalls REQ with outputs held; no response backpressure. Option: BUS_MEM_CTRL_WRITE_ACK_EN.
module bus_mem_ctrl
    import bus_mem_ctrl_pkg::*;
#(
    parameter int block_size_p     = BLOCK_SIZE,
    parameter int dma_data_width_p = DMA_DATA_WIDTH
) (
    input  logic            clk_i,
    input  logic            reset_i,
    bus_mem_ctrl_if.slave   bus
);

    localparam int block_bits_lp = block_size_p * 32;
    localparam int beats_lp      = block_bits_lp / dma_data_width_p;
    localparam int cnt_w_lp      = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int beat_bytes_lp = dma_data_width_p / 8;

    bus_mem_state_e              state_q, state_d;
    logic [cnt_w_lp-1:0]         cnt_q, cnt_d;
    logic                        we_q, we_d;
    logic [31:0]                 base_q, base_d;
    logic [block_bits_lp-1:0]    wdata_q, wdata_d;
    logic                        cb_valid_q, cb_valid_d;
    logic [dma_data_width_p-1:0] cb_data_q, cb_data_d;

    logic                        cb_yumi;
    logic                        mem_valid;
    logic                        mem_we;
    logic [31:0]                 mem_addr;
    logic [dma_data_width_p-1:0] mem_wdata;
    logic                        last_beat;

    assign last_beat = (cnt_q == cnt_w_lp'(beats_lp - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        cb_valid_d = 1'b0;
        cb_data_d  = cb_data_q;
        cb_yumi    = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                cb_yumi = bus.cb_valid_i && !reset_i;
                if (cb_yumi) begin
                    we_d    = bus.cb_pkt_i.we;
                    base_d  = bus.cb_pkt_i.addr & ~32'(block_size_p * 4 - 1);
                    wdata_d = bus.cb_pkt_i.wdata;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_we    = we_q;
                mem_addr  = base_q + (32'(cnt_q) * 32'(beat_bytes_lp));
                mem_wdata = wdata_q[cnt_q * dma_data_width_p +: dma_data_width_p];
                if (bus.mem_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_valid_i) begin
                    if (!we_q) begin
                        cb_valid_d = 1'b1;
                        cb_data_d  = bus.mem_data_i;
                    end
`ifdef BUS_MEM_CTRL_WRITE_ACK_EN
                    else if (last_beat) begin
                        // Zero-data pulse tells the cache the whole block is written.
                        cb_valid_d = 1'b1;
                        cb_data_d  = '0;
                    end
`endif
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + cnt_w_lp'(1);
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            cb_valid_q <= 1'b0;
            cb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            cb_valid_q <= cb_valid_d;
            cb_data_q  <= cb_data_d;
        end
    end

    assign bus.cb_yumi_o   = cb_yumi;
    assign bus.cb_valid_o  = cb_valid_q;
    assign bus.cb_data_o   = cb_data_q;
    assign bus.mem_valid_o = mem_valid;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench for bus_mem_ctrl: scripted cache packets against a fixed-latency memory model.
// Memory read data for byte address a is {16'hA0A0, a[15:0]}.
module tb_bus_mem_ctrl;
    import bus_mem_ctrl_pkg::*;

`ifdef BUS_MEM_CTRL_WRITE_ACK_EN
    localparam int ACK_N = 1;
`else
    localparam int ACK_N = 0;
`endif

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    bus_mem_ctrl_if bus ();

    bus_mem_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle
    logic [31:0] hs_addr[$];
    logic        hs_we[$];
    logic [31:0] hs_wdata[$];
    logic [31:0] cb_dat[$];
    int          cb_cyc[$];
    int          yu_cyc[$];
    int          mv_cyc[$];

    always @(negedge clk) begin
        if (bus.mem_valid_o && bus.mem_ready_i) begin
            hs_addr.push_back(bus.mem_addr_o);
            hs_we.push_back(bus.mem_we_o);
            hs_wdata.push_back(bus.mem_wdata_o);
        end
        if (bus.cb_valid_o) begin
            cb_dat.push_back(bus.cb_data_o);
            cb_cyc.push_back(cyc);
        end
        if (bus.cb_yumi_o) yu_cyc.push_back(cyc);
        if (bus.mem_valid_i) mv_cyc.push_back(cyc);
    end

    // Memory model: response pulse two cycles after each accepted request
    logic        mem_auto = 1'b1;
    logic        auto_mv  = 1'b0;
    logic [31:0] auto_dat = '0;
    logic        man_mv   = 1'b0;
    logic [31:0] man_dat  = '0;
    int          hs_done  = 0;
    bit          pend     = 1'b0;
    logic [31:0] p_addr   = '0;

    always @(posedge clk) begin
        #1;
        if (hs_addr.size() != hs_done) begin
            hs_done  = hs_addr.size();
            p_addr   = hs_addr[hs_done-1];
            pend     = 1'b1;
            auto_mv  = 1'b0;
            auto_dat = '0;
        end else if (pend) begin
            pend     = 1'b0;
            auto_mv  = 1'b1;
            auto_dat = {16'hA0A0, p_addr[15:0]};
        end else begin
            auto_mv  = 1'b0;
            auto_dat = '0;
        end
    end

    assign bus.mem_valid_i = mem_auto ? auto_mv  : man_mv;
    assign bus.mem_data_i  = mem_auto ? auto_dat : man_dat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic we, input logic [31:0] addr,
                            input logic [BLOCK_SIZE*32-1:0] wdata);
        bit got = 1'b0;
        bus.cb_pkt_i.we    = we;
        bus.cb_pkt_i.addr  = addr;
        bus.cb_pkt_i.wdata = wdata;
        bus.cb_valid_i     = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.cb_yumi_o) got = 1'b1;
            step();
        end
        bus.cb_valid_i = 1'b0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL send_yumi addr=%h: no cb_yumi_o within 200 cycles", addr);
        end
    endtask

    task automatic wait_hs(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (hs_addr.size() >= n) done = 1'b1;
        end
        step();
        repeat (6) step();
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL wait_hs: got %0d requests, want %0d", hs_addr.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_i            = 1'b1;
        bus.cb_valid_i     = 1'b1;
        bus.cb_pkt_i       = '0;
        bus.mem_ready_i    = 1'b0;
        repeat (3) step();
        @(negedge clk);
        tests++;
        if ({bus.cb_yumi_o, bus.cb_valid_o, bus.mem_valid_o, bus.mem_we_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: yumi/cbv/memv/we=%b want 0000",
                     {bus.cb_yumi_o, bus.cb_valid_o, bus.mem_valid_o, bus.mem_we_o});
        end
        tests++;
        if ({bus.mem_addr_o, bus.mem_wdata_o, bus.cb_data_o} !== 96'h0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h cbdata=%h want 0",
                     bus.mem_addr_o, bus.mem_wdata_o, bus.cb_data_o);
        end
        step();
        reset_i        = 1'b0;
        bus.cb_valid_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        int hb = hs_addr.size();
        int cb = cb_dat.size();
        int yb = yu_cyc.size();
        logic [31:0] exp_a, exp_d;
        bus.mem_ready_i = 1'b1;
        send_pkt(1'b0, 32'h0000_0104, '0);
        wait_hs(hb + 4);
        tests++;
        if (hs_addr.size() - hb != 4) begin
            fails++;
            $display("FAIL read_nreq: got %0d want 4", hs_addr.size() - hb);
        end
        for (int k = 0; k < 4 && hb + k < hs_addr.size(); k++) begin
            exp_a = 32'h100 + 32'(4 * k);
            tests++;
            if ({hs_we[hb+k], hs_addr[hb+k]} !== {1'b0, exp_a}) begin
                fails++;
                $display("FAIL read_req%0d: we=%b addr=%h want we=0 addr=%h",
                         k, hs_we[hb+k], hs_addr[hb+k], exp_a);
            end
        end
        tests++;
        if (cb_dat.size() - cb != 4) begin
            fails++;
            $display("FAIL read_nresp: got %0d want 4", cb_dat.size() - cb);
        end
        for (int k = 0; k < 4 && cb + k < cb_dat.size(); k++) begin
            exp_d = 32'hA0A0_0100 + 32'(4 * k);
            tests++;
            if (cb_dat[cb+k] !== exp_d) begin
                fails++;
                $display("FAIL read_data%0d: got %h want %h", k, cb_dat[cb+k], exp_d);
            end
        end
        if (cb_dat.size() - cb == 4 && yu_cyc.size() > yb) begin
            tests++;
            if (cb_cyc[cb] - yu_cyc[yb] != 4 || cb_cyc[cb+3] - cb_cyc[cb] != 9) begin
                fails++;
                $display("FAIL read_timing: first=%0d span=%0d want 4 and 9",
                         cb_cyc[cb] - yu_cyc[yb], cb_cyc[cb+3] - cb_cyc[cb]);
            end
        end
    endtask

    task automatic test_write();
        int hb = hs_addr.size();
        int cb = cb_dat.size();
        logic [31:0] exp_w[4] = '{32'hD0D0_0000, 32'hD1D1_0001, 32'hD2D2_0002, 32'hD3D3_0003};
        logic [31:0] exp_a;
        bus.mem_ready_i = 1'b1;
        send_pkt(1'b1, 32'h0000_0200,
                 {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
        wait_hs(hb + 4);
        for (int k = 0; k < 4 && hb + k < hs_addr.size(); k++) begin
            exp_a = 32'h200 + 32'(4 * k);
            tests++;
            if ({hs_we[hb+k], hs_addr[hb+k], hs_wdata[hb+k]} !== {1'b1, exp_a, exp_w[k]}) begin
                fails++;
                $display("FAIL write_req%0d: we=%b addr=%h wdata=%h want 1 %h %h",
                         k, hs_we[hb+k], hs_addr[hb+k], hs_wdata[hb+k], exp_a, exp_w[k]);
            end
        end
        tests++;
        if (cb_dat.size() - cb != ACK_N) begin
            fails++;
            $display("FAIL write_resp: got %0d cb pulses want %0d", cb_dat.size() - cb, ACK_N);
        end
`ifdef BUS_MEM_CTRL_WRITE_ACK_EN
        if (cb_dat.size() - cb == 1) begin
            tests++;
            if (cb_dat[cb] !== 32'h0 || cb_cyc[cb] != mv_cyc[mv_cyc.size()-1] + 1) begin
                fails++;
                $display("FAIL write_ack: data=%h cyc=%0d want 0 at %0d",
                         cb_dat[cb], cb_cyc[cb], mv_cyc[mv_cyc.size()-1] + 1);
            end
        end
`endif
    endtask

    task automatic test_stall();
        int hb = hs_addr.size();
        bus.mem_ready_i = 1'b0;
        send_pkt(1'b1, 32'h0000_040C,
                 {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.mem_valid_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o} !==
                {1'b1, 1'b1, 32'h400, 32'h4444_0000}) begin
                fails++;
                $display("FAIL stall_hold%0d: v=%b we=%b addr=%h wdata=%h want 1 1 400 44440000",
                         i, bus.mem_valid_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
            end
            step();
        end
        bus.mem_ready_i = 1'b1;
        step();
        bus.mem_ready_i = 1'b0;
        repeat (6) step();
        @(negedge clk);
        tests++;
        if (hs_addr.size() - hb != 1 || bus.mem_addr_o !== 32'h404) begin
            fails++;
            $display("FAIL stall_one: got %0d beats next addr %h want 1 beat next 404",
                     hs_addr.size() - hb, bus.mem_addr_o);
        end
        step();
        bus.mem_ready_i = 1'b1;
        wait_hs(hb + 4);
    endtask

    task automatic test_back_to_back();
        int hb = hs_addr.size();
        int cb = cb_dat.size();
        int yb = yu_cyc.size();
        int mb = mv_cyc.size();
        bus.mem_ready_i    = 1'b1;
        bus.cb_pkt_i.we    = 1'b0;
        bus.cb_pkt_i.addr  = 32'h0000_0100;
        bus.cb_pkt_i.wdata = '0;
        bus.cb_valid_i     = 1'b1;
        for (int i = 0; i < 50 && yu_cyc.size() == yb; i++) step();
        bus.cb_pkt_i.we    = 1'b1;
        bus.cb_pkt_i.addr  = 32'h0000_0300;
        bus.cb_pkt_i.wdata = {4{32'h3333_3333}};
        for (int i = 0; i < 100 && yu_cyc.size() < yb + 2; i++) step();
        bus.cb_valid_i = 1'b0;
        wait_hs(hb + 8);
        tests++;
        if (yu_cyc.size() - yb != 2) begin
            fails++;
            $display("FAIL b2b_yumi_count: got %0d want 2", yu_cyc.size() - yb);
        end
        if (yu_cyc.size() - yb >= 2 && mv_cyc.size() - mb >= 4 && cb_dat.size() - cb >= 4) begin
            tests++;
            if (yu_cyc[yb+1] != mv_cyc[mb+3] + 1 || cb_cyc[cb+3] != yu_cyc[yb+1]) begin
                fails++;
                $display("FAIL b2b_timing: yumi2=%0d last_resp=%0d want both %0d",
                         yu_cyc[yb+1], cb_cyc[cb+3], mv_cyc[mb+3] + 1);
            end
        end
        tests++;
        if (cb_dat.size() - cb != 4 + ACK_N) begin
            fails++;
            $display("FAIL b2b_resp: got %0d want %0d", cb_dat.size() - cb, 4 + ACK_N);
        end
        if (hs_addr.size() - hb >= 5) begin
            tests++;
            if ({hs_addr[hb+3], hs_we[hb+4], hs_addr[hb+4]} !== {32'h10C, 1'b1, 32'h300}) begin
                fails++;
                $display("FAIL b2b_pkts: a3=%h we4=%b a4=%h want 10C 1 300",
                         hs_addr[hb+3], hs_we[hb+4], hs_addr[hb+4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hb = hs_addr.size();
        int cb;
        bit seen = 1'b0;
        bus.mem_ready_i = 1'b1;
        send_pkt(1'b0, 32'h0000_0100, '0);
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (hs_addr.size() >= hb + 2) seen = 1'b1;
        end
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        cb = cb_dat.size();
        @(negedge clk);
        tests++;
        if ({bus.cb_yumi_o, bus.cb_valid_o, bus.mem_valid_o, bus.mem_we_o,
             bus.mem_addr_o, bus.mem_wdata_o, bus.cb_data_o} !== 100'h0) begin
            fails++;
            $display("FAIL rstmid_out: v=%b memv=%b addr=%h cbdata=%h want all 0",
                     bus.cb_valid_o, bus.mem_valid_o, bus.mem_addr_o, bus.cb_data_o);
        end
        repeat (8) step();
        tests++;
        if (cb_dat.size() != cb || hs_addr.size() - hb != 2) begin
            fails++;
            $display("FAIL rstmid_stray: resp=%0d reqs=%0d want 0 and 2",
                     cb_dat.size() - cb, hs_addr.size() - hb);
        end
        hb = hs_addr.size();
        bus.cb_pkt_i.we   = 1'b0;
        bus.cb_pkt_i.addr = 32'h0000_0188;
        bus.cb_valid_i    = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.cb_yumi_o !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_idle: yumi=%b want 1", bus.cb_yumi_o);
        end
        step();
        bus.cb_valid_i = 1'b0;
        wait_hs(hb + 4);
        if (hs_addr.size() > hb) begin
            tests++;
            if (hs_addr[hb] !== 32'h180) begin
                fails++;
                $display("FAIL rstmid_cnt: first addr=%h want 180", hs_addr[hb]);
            end
        end
    endtask

    task automatic test_spurious();
        int hb, cb;
        mem_auto        = 1'b0;
        man_mv          = 1'b1;
        man_dat         = 32'hDEAD_BEEF;
        bus.mem_ready_i = 1'b1;
        bus.cb_valid_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.cb_yumi_o, bus.cb_valid_o, bus.mem_valid_o, bus.mem_we_o} !== 4'b0) begin
                fails++;
                $display("FAIL spur_idle%0d: yumi/cbv/memv/we=%b want 0000", i,
                         {bus.cb_yumi_o, bus.cb_valid_o, bus.mem_valid_o, bus.mem_we_o});
            end
            step();
        end
        man_mv = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.cb_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL spur_idle_resp: cb_valid_o=%b want 0", bus.cb_valid_o);
        end
        step();
        hb = hs_addr.size();
        cb = cb_dat.size();
        send_pkt(1'b0, 32'h0000_0500, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.mem_valid_o, bus.cb_valid_o} !== 2'b00) begin
                fails++;
                $display("FAIL spur_wait%0d: memv/cbv=%b want 00", i,
                         {bus.mem_valid_o, bus.cb_valid_o});
            end
            step();
        end
        man_dat = 32'h1234_5678;
        man_mv  = 1'b1;
        step();
        man_mv  = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.cb_valid_o, bus.cb_data_o} !== {1'b1, 32'h1234_5678} || hs_addr.size() - hb != 1) begin
            fails++;
            $display("FAIL spur_wait_resp: v=%b data=%h reqs=%0d want 1 12345678 1",
                     bus.cb_valid_o, bus.cb_data_o, hs_addr.size() - hb);
        end
        step();
        mem_auto = 1'b1;
        wait_hs(hb + 4);
        if (hs_addr.size() - hb >= 2) begin
            tests++;
            if (hs_addr[hb+1] !== 32'h504 || cb_dat.size() - cb != 4) begin
                fails++;
                $display("FAIL spur_finish: addr1=%h resp=%0d want 504 and 4",
                         hs_addr[hb+1], cb_dat.size() - cb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
